// File: rtl/imem_arb_pkg.sv
// ============================================================================
//  Module      : imem_arb_pkg
//  Description : Shared types and constants for the instruction-memory
//                arbiter (arbiter states, response owner, memory depth).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_arb_pkg;

    // Depth of the instruction memory in 32-bit words
    localparam int IMEM_WORDS = 4096;

    typedef enum logic [1:0] {
        ARB_FETCH    = 2'd0,
        ARB_FORCE_LD = 2'd1,
        ARB_LOCKED   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LD    = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/imem_arb_if.sv
// ============================================================================
//  Module      : imem_arb_if
//  Description : Bundle of the fetch, loader and memory-side signals of the
//                instruction-memory arbiter. The slave modport is the arbiter
//                view, the master modport is the surrounding system view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_arb_if
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = $clog2(IMEM_WORDS)
);
    // IF-stage fetch port
    logic              fetch_req_i;
    logic [31:0]       fetch_addr_i;
    logic              fetch_gnt_o;
    logic              fetch_rvalid_o;
    logic [31:0]       fetch_rdata_o;
    // Loader / debug port
    logic              ld_req_i;
    logic              ld_we_i;
    logic [31:0]       ld_addr_i;
    logic [31:0]       ld_wdata_i;
    logic              ld_lock_i;
    logic              ld_gnt_o;
    logic              ld_rvalid_o;
    logic [31:0]       ld_rdata_o;
    logic              locked_o;
    // Memory side
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        input  ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
        input  mem_rdata_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        output ld_gnt_o, ld_rvalid_o, ld_rdata_o, locked_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i,
        output ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
        output mem_rdata_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        input  ld_gnt_o, ld_rvalid_o, ld_rdata_o, locked_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

`default_nettype wire

// File: rtl/imem_arb_fair.sv
// ============================================================================
//  Module      : imem_arb_fair
//  Description : Fairness run counter. Counts fetch grants taken while the
//                loader waits and flags the grant that exhausts the allowed
//                run, so the next cycle goes to the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arb_fair #(
    parameter int MAX_FETCH_RUN = 8
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic fetch_gnt,
    input  wire logic ld_req,
    input  wire logic clear,
    output logic      force_ld
);
    // Count value held just before the run-exhausting grant
    localparam logic [7:0] c_LAST = 8'(MAX_FETCH_RUN - 1);

    logic [7:0] r_run;

    // Run counter: only advances on fetch grants the loader had to watch
    always_ff @(posedge clk_i) begin
        if (rst_i || clear || !ld_req) begin
            r_run <= 8'd0;
        end else if (fetch_gnt) begin
            r_run <= r_run + 8'd1;
        end
    end

    // Looks one grant ahead so the loader wins on the very next cycle
    assign force_ld = fetch_gnt && ld_req && !clear && (r_run == c_LAST);

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
//  Module      : imem_arbiter
//  Description : Arbitrates a single-ported synchronous-read instruction
//                memory between the IF-stage fetch port (priority) and a
//                loader/debug port, with bounded loader starvation and a
//                loader lock mode. Optional stall statistics are enabled by
//                defining IMEM_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W        = $clog2(IMEM_WORDS),
    parameter int MAX_FETCH_RUN = 8
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    imem_arb_if.slave   bus
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_fetch_stall_o,
    output logic [31:0] stat_ld_stall_o
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic              r_rd_pend;
    logic              w_fetch_gnt;
    logic              w_ld_gnt;
    logic              w_locked;
    logic              w_force_ld;
    logic              w_run_clear;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_unused_addr_bits;

    // Outside ARB_FETCH the run always restarts from zero
    assign w_run_clear = w_ld_gnt || (r_state != ARB_FETCH);

    imem_arb_fair #(
        .MAX_FETCH_RUN (MAX_FETCH_RUN)
    ) u_fair (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .fetch_gnt (w_fetch_gnt),
        .ld_req    (bus.ld_req_i),
        .clear     (w_run_clear),
        .force_ld  (w_force_ld)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decode; everything is held off while reset is asserted
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_ld_gnt    = 1'b0;
        w_locked    = 1'b0;
        if (!rst_i) begin
            unique case (r_state)
                ARB_FETCH: begin
                    w_fetch_gnt = bus.fetch_req_i;
                    w_ld_gnt    = bus.ld_req_i && !bus.fetch_req_i;
                end
                ARB_FORCE_LD: begin
                    w_ld_gnt    = bus.ld_req_i;
                    w_fetch_gnt = bus.fetch_req_i && !bus.ld_req_i;
                end
                ARB_LOCKED: begin
                    w_locked    = 1'b1;
                    w_ld_gnt    = bus.ld_req_i;
                end
                default: begin
                    w_fetch_gnt = 1'b0;
                end
            endcase
        end
    end

    // Next state; lock beats a pending force
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_FETCH: begin
                if (bus.ld_lock_i) begin
                    w_state_nxt = ARB_LOCKED;
                end else if (w_force_ld) begin
                    w_state_nxt = ARB_FORCE_LD;
                end else begin
                    w_state_nxt = ARB_FETCH;
                end
            end
            ARB_FORCE_LD: w_state_nxt = ARB_FETCH;
            ARB_LOCKED:   w_state_nxt = bus.ld_lock_i ? ARB_LOCKED : ARB_FETCH;
            default:      w_state_nxt = ARB_FETCH;
        endcase
    end

    assign w_mem_en   = w_fetch_gnt || w_ld_gnt;
    assign w_mem_we   = bus.ld_we_i && w_ld_gnt;
    assign w_mem_addr = w_ld_gnt ? bus.ld_addr_i[ADDR_W+1:2]
                                 : bus.fetch_addr_i[ADDR_W+1:2];

    // Byte-lane and above-range address bits are deliberately ignored
    assign w_unused_addr_bits = ^{bus.fetch_addr_i[31:ADDR_W+2], bus.fetch_addr_i[1:0],
                                  bus.ld_addr_i[31:ADDR_W+2], bus.ld_addr_i[1:0]};

    // Remember who owns the read data arriving next cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_pend <= 1'b0;
            r_owner   <= OWN_FETCH;
        end else begin
            r_rd_pend <= w_mem_en && !w_mem_we;
            r_owner   <= w_ld_gnt ? OWN_LD : OWN_FETCH;
        end
    end

    assign bus.fetch_gnt_o    = w_fetch_gnt;
    assign bus.ld_gnt_o       = w_ld_gnt;
    assign bus.locked_o       = w_locked;
    assign bus.mem_en_o       = w_mem_en;
    assign bus.mem_we_o       = w_mem_we;
    assign bus.mem_addr_o     = w_mem_addr;
    assign bus.mem_wdata_o    = w_ld_gnt ? bus.ld_wdata_i : 32'd0;
    assign bus.fetch_rvalid_o = r_rd_pend && (r_owner == OWN_FETCH) && !rst_i;
    assign bus.ld_rvalid_o    = r_rd_pend && (r_owner == OWN_LD) && !rst_i;
    assign bus.fetch_rdata_o  = bus.mem_rdata_i;
    assign bus.ld_rdata_o     = bus.mem_rdata_i;

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] r_stat_fetch;
    logic [31:0] r_stat_ld;

    // Saturating counts of cycles each requester waited without a grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_fetch <= 32'd0;
            r_stat_ld    <= 32'd0;
        end else begin
            if (bus.fetch_req_i && !w_fetch_gnt && (r_stat_fetch != 32'hFFFF_FFFF)) begin
                r_stat_fetch <= r_stat_fetch + 32'd1;
            end
            if (bus.ld_req_i && !w_ld_gnt && (r_stat_ld != 32'hFFFF_FFFF)) begin
                r_stat_ld <= r_stat_ld + 32'd1;
            end
        end
    end

    assign stat_fetch_stall_o = r_stat_fetch;
    assign stat_ld_stall_o    = r_stat_ld;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
//  Module      : tb_imem_arbiter
//  Description : Self-checking bench for imem_arbiter: directed scenarios
//                followed by random traffic against a behavioural model of
//                the arbitration rules and of the memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_arbiter;
    import imem_arb_pkg::*;

    localparam int c_ADDR_W = 12;
    localparam int c_MAX    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_arb_if #(.ADDR_W(c_ADDR_W)) bus ();

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] stat_f;
    logic [31:0] stat_l;
`endif

    imem_arbiter #(
        .ADDR_W        (c_ADDR_W),
        .MAX_FETCH_RUN (c_MAX)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef IMEM_ARB_STATS_EN
        ,
        .stat_fetch_stall_o (stat_f),
        .stat_ld_stall_o    (stat_l)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Memory seen by the DUT (environment) and the model's own copy
    logic [31:0] mem     [IMEM_WORDS];
    logic [31:0] ref_mem [IMEM_WORDS];

    // Behavioural model state
    bit          m_locked, m_forced;
    int          m_streak;
    bit          m_pend_f, m_pend_l;
    logic [31:0] m_pend_data;
    int          m_sf, m_sl;

    // Observed values of the most recent cycle, for directed checks
    logic        o_fg, o_lg, o_locked, o_we, o_fv, o_lv;
    logic [31:0] o_addr, o_frd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % IMEM_WORDS);
    endfunction

    // One clock cycle: drive, check against the model, act as memory, advance
    task automatic step(input bit r, input bit fr, input logic [31:0] fa,
                        input bit lr, input bit lwe, input logic [31:0] la,
                        input logic [31:0] lwd, input bit lk);
        bit          e_fg, e_lg, e_lock, e_fv, e_lv, rd;
        logic [31:0] rd_next;
        @(negedge clk);
        rst              = r;
        bus.fetch_req_i  = fr;
        bus.fetch_addr_i = fa;
        bus.ld_req_i     = lr;
        bus.ld_we_i      = lwe;
        bus.ld_addr_i    = la;
        bus.ld_wdata_i   = lwd;
        bus.ld_lock_i    = lk;
        #1;
        e_lock = 1'b0;
        if (r) begin
            e_fg = 1'b0; e_lg = 1'b0;
        end else if (m_locked) begin
            e_fg = 1'b0; e_lg = lr; e_lock = 1'b1;
        end else if (m_forced && lr) begin
            e_fg = 1'b0; e_lg = 1'b1;
        end else begin
            e_fg = fr; e_lg = lr && !fr;
        end
        e_fv = !r && m_pend_f;
        e_lv = !r && m_pend_l;

        check("fetch_gnt", 32'(bus.fetch_gnt_o), 32'(e_fg));
        check("ld_gnt", 32'(bus.ld_gnt_o), 32'(e_lg));
        check("locked", 32'(bus.locked_o), 32'(e_lock));
        check("mem_en", 32'(bus.mem_en_o), 32'(e_fg || e_lg));
        check("mem_we", 32'(bus.mem_we_o), 32'(e_lg && lwe));
        check("mem_wdata", bus.mem_wdata_o, e_lg ? lwd : 32'd0);
        if (e_fg || e_lg)
            check("mem_addr", 32'(bus.mem_addr_o), 32'(e_lg ? widx(la) : widx(fa)));
        check("fetch_rvalid", 32'(bus.fetch_rvalid_o), 32'(e_fv));
        check("ld_rvalid", 32'(bus.ld_rvalid_o), 32'(e_lv));
        if (e_fv) check("fetch_rdata", bus.fetch_rdata_o, m_pend_data);
        if (e_lv) check("ld_rdata", bus.ld_rdata_o, m_pend_data);

        o_fg = bus.fetch_gnt_o;  o_lg = bus.ld_gnt_o;  o_locked = bus.locked_o;
        o_we = bus.mem_we_o;     o_fv = bus.fetch_rvalid_o; o_lv = bus.ld_rvalid_o;
        o_addr = 32'(bus.mem_addr_o); o_frd = bus.fetch_rdata_o;

        // Memory behaviour driven purely by the DUT's memory-side outputs
        rd = 1'b0;
        rd_next = 32'd0;
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
            else begin rd = 1'b1; rd_next = mem[bus.mem_addr_o]; end
        end

        // Model update from the arbitration rules
        if (r) begin
            m_locked = 1'b0; m_forced = 1'b0; m_streak = 0;
            m_pend_f = 1'b0; m_pend_l = 1'b0; m_sf = 0; m_sl = 0;
        end else begin
            m_sf += int'(fr && !e_fg);
            m_sl += int'(lr && !e_lg);
            m_pend_f = e_fg;
            m_pend_l = e_lg && !lwe;
            if (e_fg) m_pend_data = ref_mem[widx(fa)];
            else if (e_lg && !lwe) m_pend_data = ref_mem[widx(la)];
            if (e_lg && lwe) ref_mem[widx(la)] = lwd;
            if (m_locked) begin
                m_locked = lk; m_streak = 0;
            end else if (m_forced) begin
                m_forced = 1'b0; m_streak = 0;
            end else if (lk) begin
                m_locked = 1'b1; m_streak = 0;
            end else begin
                if (!lr || e_lg) m_streak = 0;
                else if (e_fg) m_streak++;
                if (m_streak == c_MAX) m_forced = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        if (rd) bus.mem_rdata_i = rd_next;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b0, 1'b1, a, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        int first_ld;
        int lock_run;
        bit          r_fr, r_lr, r_we, r_lk, r_rst;
        logic [31:0] r_fa, r_la;

        rst = 1'b1;
        bus.fetch_req_i = 1'b0; bus.fetch_addr_i = 32'd0;
        bus.ld_req_i = 1'b0; bus.ld_we_i = 1'b0; bus.ld_addr_i = 32'd0;
        bus.ld_wdata_i = 32'd0; bus.ld_lock_i = 1'b0; bus.mem_rdata_i = 32'd0;
        for (int i = 0; i < IMEM_WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end

        // Reset with requests active: every grant/strobe held low
        step(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h1, 1'b1);
        step(1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h1, 1'b0);
        idle();

        // Fetch alone, back-to-back words 0,1,2
        fetch(32'h0); check("seq_addr0", o_addr, 32'd0);
        fetch(32'h4); check("seq_addr1", o_addr, 32'd1);
        fetch(32'h8); check("seq_addr2", o_addr, 32'd2);
        idle();

        // Contention: loader gets the 9th cycle
        first_ld = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
            if (o_lg && first_ld < 0) begin
                first_ld = i;
                check("force_addr", o_addr, 32'd4);
                check("force_fetch_denied", 32'(o_fg), 32'd0);
            end
        end
        check("force_first_ld_cycle", 32'(first_ld), 32'd8);
        idle();

        // Lock: loader writes while fetch is held off
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b1);
        check("lock_fetch_gnt", 32'(o_fg), 32'd0);
        check("lock_locked", 32'(o_locked), 32'd1);
        check("lock_we", 32'(o_we), 32'd1);
        check("lock_addr", o_addr, 32'd8);
        step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        fetch(32'h20);
        idle();
        check("lock_readback_valid", 32'(o_fv), 32'd1);
        check("lock_readback", o_frd, 32'hDEADBEEF);

        // Wrapped, unaligned address
        fetch(32'h4003);
        check("wrap_addr", o_addr, 32'd0);
        idle();

        // Write then read of the same word in consecutive cycles
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 1'b0);
        fetch(32'h30);
        idle();
        check("raw_data", o_frd, 32'h1234_5678);

        // Reset right after an accepted read discards the response
        fetch(32'h8);
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'd0, 1'b0);
        check("rst_rvalid", 32'(o_fv), 32'd0);
        idle();
        check("post_rst_rvalid", 32'({o_fv, o_lv}), 32'd0);

        // Random traffic
        lock_run = 0;
        for (int i = 0; i < 600; i++) begin
            r_fr  = ($urandom_range(0, 3) != 0);
            r_lr  = $urandom_range(0, 1) == 1;
            r_we  = $urandom_range(0, 1) == 1;
            r_fa  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
            r_la  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
            r_rst = ($urandom_range(0, 99) == 0);
            if (lock_run > 0) begin
                r_lk = 1'b1;
                lock_run--;
            end else begin
                r_lk = 1'b0;
                if ($urandom_range(0, 31) == 0) lock_run = $urandom_range(1, 6);
            end
            step(r_rst, r_fr, r_fa, r_lr, r_we, r_la, $urandom, r_lk);
        end
        idle();

`ifdef IMEM_ARB_STATS_EN
        check("stat_fetch_stall", stat_f, 32'(m_sf));
        check("stat_ld_stall", stat_l, 32'(m_sl));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
